// File: rtl/direct_cache_ctrl.sv
// Direct-mapped, single-word-line, write-through cache controller in front of a
// fixed-latency main memory with no ready signal; memory accesses are timed by a counter.
module direct_cache_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINES      = 16,
    parameter int unsigned MEM_DELAY  = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;
    localparam int unsigned CNT_W = $clog2(MEM_DELAY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        PARK,
        MEM_WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                 state, state_d;
    req_t                   req_q, req_d;
    logic [CNT_W-1:0]       wait_cnt, wait_cnt_d;

    logic [DATA_WIDTH-1:0]  rdata_d;
    logic                   ack_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic                   mem_we_d;
    logic [DATA_WIDTH-1:0]  mem_data_in_d;
    logic [15:0]            hit_d, miss_d;

    // Line storage: only the valid bits need a reset.
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [DATA_WIDTH-1:0]  data_q [LINES];

    logic                   line_we;
    logic                   line_fill;
    logic [IDX_W-1:0]       line_idx;
    logic [TAG_W-1:0]       line_tag;
    logic [DATA_WIDTH-1:0]  line_data;

    logic [IDX_W-1:0]       cpu_idx, req_idx;
    logic [TAG_W-1:0]       cpu_tag, req_tag;
    logic                   cpu_hit, req_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cpu_idx = cpu_addr[IDX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_WIDTH-1:IDX_W];
    assign req_idx = req_q.addr[IDX_W-1:0];
    assign req_tag = req_q.addr[ADDR_WIDTH-1:IDX_W];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        req_d         = req_q;
        wait_cnt_d    = wait_cnt;
        rdata_d       = cpu_rdata;
        ack_d         = 1'b0;
        mem_addr_d    = mem_addr;
        mem_we_d      = mem_we;
        mem_data_in_d = mem_data_in;
        hit_d         = hit_count;
        miss_d        = miss_count;
        line_we       = 1'b0;
        line_fill     = 1'b0;
        line_idx      = req_idx;
        line_tag      = req_tag;
        line_data     = mem_data_out;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    req_d = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
                    if (!cpu_we && cpu_hit) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        rdata_d = data_q[cpu_idx];
                        hit_d   = sat_inc(hit_count);
                    end else begin
                        if (!cpu_we) begin
                            miss_d = sat_inc(miss_count);
                        end
                        wait_cnt_d = '0;
                        // mem_addr doubles as the last driven address; memory needs an
                        // address change to start, so detour through a neighbour first.
                        if (cpu_addr == mem_addr) begin
                            state_d    = PARK;
                            mem_addr_d = cpu_addr ^ ADDR_WIDTH'(1);
                            mem_we_d   = 1'b0;
                        end else begin
                            state_d       = MEM_WAIT;
                            mem_addr_d    = cpu_addr;
                            mem_we_d      = cpu_we;
                            mem_data_in_d = cpu_wdata;
                        end
                    end
                end
            end

            PARK: begin
                state_d       = MEM_WAIT;
                mem_addr_d    = req_q.addr;
                mem_we_d      = req_q.we;
                mem_data_in_d = req_q.wdata;
                wait_cnt_d    = '0;
            end

            MEM_WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    state_d  = RESP;
                    ack_d    = 1'b1;
                    mem_we_d = 1'b0;
                    if (!req_q.we) begin
                        rdata_d   = mem_data_out;
                        line_we   = 1'b1;
                        line_fill = 1'b1;
                    end else if (req_hit) begin
                        line_we   = 1'b1;
                        line_data = req_q.wdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= '0;
            wait_cnt    <= '0;
            cpu_rdata   <= '0;
            cpu_ack     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_data_in <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            state       <= state_d;
            req_q       <= req_d;
            wait_cnt    <= wait_cnt_d;
            cpu_rdata   <= rdata_d;
            cpu_ack     <= ack_d;
            mem_addr    <= mem_addr_d;
            mem_we      <= mem_we_d;
            mem_data_in <= mem_data_in_d;
            hit_count   <= hit_d;
            miss_count  <= miss_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (line_fill) begin
            valid_q[line_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[line_idx] <= line_data;
            if (line_fill) begin
                tag_q[line_idx] <= line_tag;
            end
        end
    end

endmodule

// File: tb/tb_direct_cache_ctrl.sv
// Directed bench for direct_cache_ctrl with a behavioural fixed-latency main memory
// (mem[i] = i[7:0], completes DELAY-1 edges after an address change).
module tb_direct_cache_ctrl;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned DELAY = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic [15:0]   hit_count, miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    direct_cache_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINES(16), .MEM_DELAY(DELAY)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Main memory model: restarts on every address change, no ready signal.
    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] seen_addr = '0;
    int            mcnt = 0;
    logic          busy = 1'b0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
        mem_data_out = '0;
    end

    always @(posedge clk) begin
        if (mem_addr != seen_addr) begin
            seen_addr <= mem_addr;
            mcnt      <= 1;
            busy      <= 1'b1;
        end else if (busy) begin
            if (mcnt == DELAY - 2) begin
                if (mem_we) mem[mem_addr] <= mem_data_in;
                mem_data_out <= mem_we ? mem_data_in : mem[mem_addr];
                busy         <= 1'b0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    // Issue one request; lat is j where cpu_ack rose at edge k+j (k = sampling edge).
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output int lat, output logic [DW-1:0] rd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        lat = 0;
        while (!cpu_ack && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cpu_ack) check("ack_timeout", 32'(cpu_ack), 32'd1);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(cpu_ack), 32'd0);
    endtask

    task automatic step(input string name, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int exp_lat, input logic [DW-1:0] exp_rd);
        int            lat;
        logic [DW-1:0] rd;
        do_req(we, addr, wd, lat, rd);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, 32'(rd), 32'(exp_rd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    logic ack_seen;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(cpu_ack),     32'd0);
        check("rst_rdata", 32'(cpu_rdata),   32'd0);
        check("rst_maddr", 32'(mem_addr),    32'd0);
        check("rst_mwe",   32'(mem_we),      32'd0);
        check("rst_mdin",  32'(mem_data_in), 32'd0);
        check("rst_hits",  32'(hit_count),   32'd0);
        check("rst_miss",  32'(miss_count),  32'd0);
        @(negedge clk); reset = 1'b0;

        // Miss without park, then hit.
        step("rd005_miss", 1'b0, 10'h005, 8'h00, DELAY, 8'h05);
        check("miss_after_rd005", 32'(miss_count), 32'd1);
        step("rd005_hit", 1'b0, 10'h005, 8'h00, 0, 8'h05);
        check("hits_after_rd005", 32'(hit_count), 32'd1);

        // Address 0 right after reset must park.
        do_reset();
        step("rd000_park", 1'b0, 10'h000, 8'h00, DELAY + 1, 8'h00);
        check("miss_after_rd000", 32'(miss_count), 32'd1);
        check("hits_after_reset", 32'(hit_count), 32'd0);

        step("rd005_fill", 1'b0, 10'h005, 8'h00, DELAY, 8'h05);
        step("rd000_hit", 1'b0, 10'h000, 8'h00, 0, 8'h00);
        step("rd003_miss", 1'b0, 10'h003, 8'h00, DELAY, 8'h03);
        // Write hit: rdata keeps the previous read value.
        step("wr005_hit", 1'b1, 10'h005, 8'hAA, DELAY, 8'h03);
        check("mwe_after_wr", 32'(mem_we), 32'd0);
        step("rd005_after_wr", 1'b0, 10'h005, 8'h00, 0, 8'hAA);
        step("rd015_conflict", 1'b0, 10'h015, 8'h00, DELAY, 8'h15);
        step("rd005_evicted", 1'b0, 10'h005, 8'h00, DELAY, 8'hAA);

        // Write miss does not allocate; following read parks on the same address.
        step("wr040_miss", 1'b1, 10'h040, 8'h11, DELAY, 8'hAA);
        step("rd040_park", 1'b0, 10'h040, 8'h00, DELAY + 1, 8'h11);
        step("rd000_still", 1'b0, 10'h000, 8'h00, DELAY, 8'h00);
        check("hits_total", 32'(hit_count), 32'd2);
        check("miss_total", 32'(miss_count), 32'd7);

        // Reset 20 cycles into a read miss.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h007; cpu_wdata = '0;
        ack_seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | cpu_ack;
        end
        check("inflight_maddr", 32'(mem_addr), 32'h007);
        reset = 1'b1;
        #1;
        cpu_req = 1'b0;
        check("midrst_mwe",   32'(mem_we),     32'd0);
        check("midrst_maddr", 32'(mem_addr),   32'd0);
        check("midrst_hits",  32'(hit_count),  32'd0);
        check("midrst_miss",  32'(miss_count), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | cpu_ack;
        end
        check("midrst_no_ack", 32'(ack_seen), 32'd0);
        @(negedge clk); reset = 1'b0;
        step("rd005_after_rst", 1'b0, 10'h005, 8'h00, DELAY, 8'hAA);
        check("miss_after_rst", 32'(miss_count), 32'd1);
        check("hits_after_rst", 32'(hit_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
